cpu_hex_scan: RTL and testbench

//  Avalon-MM slave driving a multiplexed NUM_DIGITS 7-segment display: hex decode, per-digit DP/blank, blink.

---
 rtl/cpu_hex_scan.sv | 177 +++++++++++++++++
 tb/tb_cpu_hex_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_hex_scan.sv
// Avalon-MM controller for a multiplexed hex 7-segment display.
// One digit slot per SCAN_DIV cycles, with anti-ghost blanking, per-digit DP/blank and frame-based blink.

module cpu_hex_scan_lane (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    // Active-high {g,f,e,d,c,b,a}
    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end
endmodule

module cpu_hex_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Register file
    logic [1:0]                  ctrl;
    logic [NUM_DIGITS-1:0][3:0]  digit_val;
    logic [NUM_DIGITS-1:0]       dp_mask;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic [15:0]                 blink_per;

    // Scan / blink state
    logic [PW-1:0]               presc;
    logic [IW-1:0]               idx;
    logic [15:0]                 frame_cnt;
    logic                        blink_ph;

    logic                        en, blink_en;
    logic                        wr_en, blink_wr;
    logic                        slot_end, last_dig, frame_end;
    logic                        dig_on;
    logic [NUM_DIGITS-1:0]       dig_nxt;
    logic [NUM_DIGITS-1:0][6:0]  lane_seg;
    logic                        unused_wd;

    assign en        = ctrl[0];
    assign blink_en  = ctrl[1];
    assign wr_en     = chipselect & ~write_n;
    assign blink_wr  = wr_en && (address == 2'd3);
    assign slot_end  = (presc == PRESC_LAST);
    assign last_dig  = (idx == IDX_LAST);
    assign frame_end = en && slot_end && last_dig;
    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl       <= '0;
            digit_val  <= '0;
            dp_mask    <= '0;
            blank_mask <= '0;
            blink_per  <= '0;
        end else if (wr_en) begin
            case (address)
                2'd0: ctrl      <= writedata[1:0];
                2'd1: digit_val <= writedata[4*NUM_DIGITS-1:0];
                2'd2: begin
                    dp_mask    <= writedata[NUM_DIGITS-1:0];
                    blank_mask <= writedata[8+NUM_DIGITS-1:8];
                end
                default: blink_per <= writedata[15:0];
            endcase
        end
    end

    // Disabled scanning parks on digit 0 so re-enabling starts with a full blanking interval
    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= last_dig ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A BLINK write restarts the visible half-period immediately
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (blink_wr || (blink_per == 16'd0)) begin
            frame_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == blink_per - 16'd1) begin
                frame_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        cpu_hex_scan_lane u_lane (
            .nibble (digit_val[g]),
            .seg    (lane_seg[g])
        );
    end

    always_comb begin
        dig_on  = en && (presc >= BLANK_END) && !blank_mask[idx] && !(blink_en && !blink_ph);
        dig_nxt = '0;
        if (dig_on)
            dig_nxt[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg <= {7{SEG_ACTIVE_LOW}};
            dp  <= SEG_ACTIVE_LOW;
            dig <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            seg <= lane_seg[idx] ^ {7{SEG_ACTIVE_LOW}};
            dp  <= dp_mask[idx] ^ SEG_ACTIVE_LOW;
            dig <= dig_nxt ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[1:0] = ctrl;
            2'd1: readdata[4*NUM_DIGITS-1:0] = digit_val;
            2'd2: begin
                readdata[NUM_DIGITS-1:0]      = dp_mask;
                readdata[8+NUM_DIGITS-1:8]    = blank_mask;
            end
            default: readdata[15:0] = blink_per;
        endcase
    end
endmodule

// File: tb/tb_cpu_hex_scan.sv
// Directed bench for cpu_hex_scan at SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=4.
module tb_cpu_hex_scan;
    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [6:0] TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    cpu_hex_scan #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg        (seg),
        .dp         (dp),
        .dig        (dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string tag);
        address = a;
        #1;
        chk(tag, readdata, e);
    endtask

    // k = cycles since the enabling write edge; output shows slot state from cycle k-1
    task automatic scan_chk(input int k, input logic [15:0] dval, input logic [3:0] dpm,
                            input logic [3:0] blk, input bit vis, input string tag);
        int p, i;
        logic [3:0] nib, ed;
        logic [6:0] es;
        logic       edp;
        p   = (k - 1) % 8;
        i   = ((k - 1) / 8) % 4;
        nib = dval[4*i +: 4];
        ed  = (p < 2 || blk[i] || !vis) ? 4'hF : ~(4'b0001 << i);
        es  = ~TAB[nib];
        edp = ~dpm[i];
        chk({tag, "_dig"}, 32'(dig), 32'(ed));
        chk({tag, "_seg"}, 32'(seg), 32'(es));
        chk({tag, "_dp"},  32'(dp),  32'(edp));
    endtask

    initial begin
        logic [3:0] prev;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;

        // T1 reset state
        tick(2);
        chk("t1_dig", 32'(dig), 32'h0000_000F);
        chk("t1_seg", 32'(seg), 32'h0000_007F);
        chk("t1_dp",  32'(dp),  32'h0000_0001);
        for (int a = 0; a < 4; a++) rd_chk(2'(a), 32'h0, "t1_rd");
        reset_n = 1'b1;
        tick(1);

        // Register map: unused bits read 0, reads ignore chipselect
        wr(2'd0, 32'hFFFF_FFFC);
        wr(2'd1, 32'hDEAD_BEEF);
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_1234);
        rd_chk(2'd0, 32'h0000_0000, "rd_ctrl");
        rd_chk(2'd1, 32'h0000_BEEF, "rd_digit");
        rd_chk(2'd2, 32'h0000_0F0F, "rd_mask");
        rd_chk(2'd3, 32'h0000_1234, "rd_blink");
        chk("en0_dig", 32'(dig), 32'h0000_000F);
        address = 2'd1; writedata = 32'h0; write_n = 1'b0; chipselect = 1'b0;
        tick(1);
        write_n = 1'b1;
        rd_chk(2'd1, 32'h0000_BEEF, "nocs_write");

        // T2 plain scan
        wr(2'd1, 32'h0000_3210);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);
        wr(2'd0, 32'h1);
        chk("t2_first", 32'(dig), 32'h0000_000F);
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            scan_chk(k, 16'h3210, 4'h0, 4'h0, 1'b1, "t2");
        end

        // T3 DP on digit 0, digit 1 blanked
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h0000_0201);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            scan_chk(k, 16'h3210, 4'b0001, 4'b0010, 1'b1, "t3");
        end

        // T4 blink 2 frames on / 2 off, then BLINK=0 mid off-phase
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h2);
        wr(2'd0, 32'h3);
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            scan_chk(k, 16'h3210, 4'h0, 4'h0, (((k - 1) / 64) % 2) == 0, "t4");
        end
        wr(2'd3, 32'h0);
        scan_chk(101, 16'h3210, 4'h0, 4'h0, 1'b0, "t4_wr");
        for (int k = 102; k <= 140; k++) begin
            tick(1);
            scan_chk(k, 16'h3210, 4'h0, 4'h0, 1'b1, "t4_steady");
        end

        // T5 decode sweep on digit 0 with scanning off
        wr(2'd0, 32'h0);
        tick(2);
        prev = 4'h0;
        for (int v = 0; v < 16; v++) begin
            logic [6:0] es;
            wr(2'd1, 32'(v));
            es = ~TAB[prev];
            chk("t5_hold", 32'(seg), 32'(es));
            tick(1);
            es = ~TAB[v];
            chk("t5_seg", 32'(seg), 32'(es));
            chk("t5_dig", 32'(dig), 32'h0000_000F);
            prev = 4'(v);
        end

        // T6 write on slot boundary, then reset mid-slot of digit 2
        wr(2'd1, 32'h0000_3210);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            scan_chk(k, 16'h3210, 4'h0, 4'h0, 1'b1, "t6_pre");
        end
        wr(2'd1, 32'h0000_3250);
        scan_chk(8, 16'h3210, 4'h0, 4'h0, 1'b1, "t6_edge");
        for (int k = 9; k <= 19; k++) begin
            tick(1);
            scan_chk(k, 16'h3250, 4'h0, 4'h0, 1'b1, "t6_new");
        end
        reset_n = 1'b0;
        tick(1);
        chk("t6_rst_dig", 32'(dig), 32'h0000_000F);
        chk("t6_rst_seg", 32'(seg), 32'h0000_007F);
        chk("t6_rst_dp",  32'(dp),  32'h0000_0001);
        rd_chk(2'd0, 32'h0, "t6_rst_ctrl");
        rd_chk(2'd1, 32'h0, "t6_rst_digit");
        reset_n = 1'b1;
        tick(1);
        chk("t6_post_dig", 32'(dig), 32'h0000_000F);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            scan_chk(k, 16'h0000, 4'h0, 4'h0, 1'b1, "t6_restart");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
